instr_sequencer: RTL and testbench

Multi-cycle fetch/decode/execute controller for the mini 8-bit CPU. Fetches 12-bit instruction words from a synchronous program ROM and splits each into a 4-bit opcode (bits 11:8) and an 8-bit operand (bits 7:0). It then drives one-cycle control strobes to the accumulator, ALU and data memory. It sits between program memory and the datapath and owns the program counter.

---
 rtl/seq_pkg.sv | 26 ++
 rtl/seq_decode.sv | 35 +++
 rtl/instr_sequencer.sv | 98 +++++++++
 tb/tb_instr_sequencer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// seq_pkg: shared opcodes, state encoding, ALU and accumulator-source codes for instr_sequencer
package seq_pkg;
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_LD  = 4'h7;
  localparam logic [3:0] OP_ST  = 4'h8;
  localparam logic [3:0] OP_JMP = 4'h9;
  localparam logic [3:0] OP_JZ  = 4'hA;
  localparam logic [3:0] OP_JNZ = 4'hB;
  localparam logic [3:0] OP_HLT = 4'hF;
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [1:0] SRC_ALU  = 2'd0;
  localparam logic [1:0] SRC_IMM  = 2'd1;
  localparam logic [1:0] SRC_DMEM = 2'd2;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT} state_t;
  typedef enum logic [1:0] {NX_BOUNDARY, NX_MEM, NX_HALT} next_t;
endpackage

// File: rtl/seq_decode.sv
// seq_decode: combinational EXEC-cycle decode of the IR opcode (SEQ_ILLEGAL_TRAP_EN enables the C-E trap)
module seq_decode
  import seq_pkg::*;
(
  input  logic [3:0] i_opcode,
  input  logic       i_zero_flag,
  output logic       o_acc_we,
  output logic [1:0] o_acc_src,
  output logic [2:0] o_alu_op,
  output logic       o_dmem_re,
  output logic       o_dmem_we,
  output logic       o_pc_load,
  output logic       o_illegal,
  output next_t      o_next
);
  logic       w_alu;
  logic [3:0] w_alu_idx;
  assign w_alu     = (i_opcode >= OP_ADD) && (i_opcode <= OP_XOR);
  assign w_alu_idx = i_opcode - OP_ADD;
  // strobes, branch decision and where the FSM goes after EXEC
  always_comb begin
    o_acc_we  = w_alu || (i_opcode == OP_LDI);
    o_acc_src = (i_opcode == OP_LDI) ? SRC_IMM : SRC_ALU;
    o_alu_op  = w_alu ? w_alu_idx[2:0] : ALU_ADD;
    o_dmem_re = i_opcode == OP_LD;
    o_dmem_we = i_opcode == OP_ST;
    o_pc_load = (i_opcode == OP_JMP) || (i_opcode == OP_JZ && i_zero_flag) || (i_opcode == OP_JNZ && !i_zero_flag);
`ifdef SEQ_ILLEGAL_TRAP_EN
    o_illegal = (i_opcode >= 4'hC) && (i_opcode <= 4'hE);
`else
    o_illegal = 1'b0;
`endif
    o_next    = (i_opcode == OP_HLT || o_illegal) ? NX_HALT : (i_opcode == OP_LD) ? NX_MEM : NX_BOUNDARY;
  end
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/decode/execute controller owning pc and IR (illegal trap via SEQ_ILLEGAL_TRAP_EN)
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int PC_W = 8,
  parameter int IW   = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  input  logic            zero_flag,
  output logic [PC_W-1:0] imem_addr,
  input  logic [IW-1:0]   imem_rdata,
  output logic [3:0]      ir_opcode,
  output logic [7:0]      ir_operand,
  output logic [2:0]      alu_op,
  output logic [1:0]      acc_src,
  output logic            acc_we,
  output logic            dmem_re,
  output logic            dmem_we,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            illegal
);
  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic [IW-1:0]   r_ir;
  logic            r_halted;
  logic            r_illegal;
  logic            w_acc_we;
  logic [1:0]      w_acc_src;
  logic [2:0]      w_alu_op;
  logic            w_dmem_re;
  logic            w_dmem_we;
  logic            w_pc_load;
  logic            w_illegal;
  next_t           w_next;
  logic            w_exec;
  logic            w_mem;

  seq_decode u_decode (
    .i_opcode   (r_ir[IW-1:IW-4]),
    .i_zero_flag(zero_flag),
    .o_acc_we   (w_acc_we),
    .o_acc_src  (w_acc_src),
    .o_alu_op   (w_alu_op),
    .o_dmem_re  (w_dmem_re),
    .o_dmem_we  (w_dmem_we),
    .o_pc_load  (w_pc_load),
    .o_illegal  (w_illegal),
    .o_next     (w_next)
  );

  assign w_exec     = r_state == S_EXEC;
  assign w_mem      = r_state == S_MEM;
  assign imem_addr  = r_pc;
  assign pc         = r_pc;
  assign ir_opcode  = r_ir[IW-1:IW-4];
  assign ir_operand = r_ir[7:0];
  assign acc_we     = (w_exec && w_acc_we) || w_mem;
  assign acc_src    = w_mem ? SRC_DMEM : w_exec ? w_acc_src : SRC_ALU;
  assign alu_op     = w_exec ? w_alu_op : ALU_ADD;
  assign dmem_re    = w_exec && w_dmem_re;
  assign dmem_we    = w_exec && w_dmem_we;
  assign halted     = r_halted;
  assign illegal    = r_illegal;

  // sequencer FSM; a branch load in EXEC overrides the increment done in DECODE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_ir      <= '0;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE:   r_state <= run ? S_FETCH : S_IDLE;
        S_FETCH:  r_state <= S_DECODE;
        S_DECODE: begin
          r_ir    <= imem_rdata;
          r_pc    <= r_pc + 1'b1;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          if (w_pc_load) r_pc <= r_ir[PC_W-1:0];
          if (w_next == NX_HALT) begin
            r_halted  <= 1'b1;
            r_illegal <= w_illegal;
          end
          r_state <= (w_next == NX_HALT) ? S_HALT : (w_next == NX_MEM) ? S_MEM : run ? S_FETCH : S_IDLE;
        end
        S_MEM:    r_state <= run ? S_FETCH : S_IDLE;
        default:  r_state <= S_HALT;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: randomized self-checking bench with an instruction-level reference model
module tb_instr_sequencer;
`ifdef SEQ_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic        zero_flag;
  logic [7:0]  imem_addr;
  logic [11:0] imem_rdata;
  logic [3:0]  ir_opcode;
  logic [7:0]  ir_operand;
  logic [2:0]  alu_op;
  logic [1:0]  acc_src;
  logic        acc_we;
  logic        dmem_re;
  logic        dmem_we;
  logic [7:0]  pc;
  logic        halted;
  logic        illegal;
  logic [11:0] rom [256];
  logic [7:0]  m_pc;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) imem_rdata <= rom[imem_addr];

  instr_sequencer dut (
    .clk(clk), .rst_n(rst_n), .run(run), .zero_flag(zero_flag),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .ir_opcode(ir_opcode), .ir_operand(ir_operand),
    .alu_op(alu_op), .acc_src(acc_src), .acc_we(acc_we),
    .dmem_re(dmem_re), .dmem_we(dmem_we), .pc(pc),
    .halted(halted), .illegal(illegal)
  );

  task automatic do_reset();
    rst_n = 1'b0;
    run = 1'b0;
    zero_flag = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_pc = 8'h00;
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    run = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 12'h000;
  endtask

  // one instruction from its FETCH cycle to the cycle after its boundary; zf: 0/1 forced, 2 random
  task automatic step_instr(input bit stop, input int zf, output bit hlt);
    logic [11:0] w;
    logic [3:0]  op;
    logic [7:0]  opd;
    logic        is_alu, is_trap, e_we, z;
    logic [1:0]  e_src;
    logic [2:0]  e_alu;
    w = rom[m_pc];
    op = w[11:8];
    opd = w[7:0];
    hlt = 1'b0;
    n_cmp++;
    if (imem_addr !== m_pc || {acc_we, dmem_re, dmem_we} !== 3'b000) begin
      n_err++;
      $display("FAIL fetch: addr=%0h strobes=%b expected addr=%0h strobes=000", imem_addr, {acc_we, dmem_re, dmem_we}, m_pc);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({acc_we, dmem_re, dmem_we} !== 3'b000) begin
      n_err++;
      $display("FAIL decode_quiet: strobes=%b expected 000", {acc_we, dmem_re, dmem_we});
    end
    @(posedge clk);
    #1;
    m_pc = m_pc + 8'd1;
    is_alu = op >= 4'd2 && op <= 4'd6;
    is_trap = TRAP && op >= 4'hC && op <= 4'hE;
    e_we = is_alu || op == 4'd1;
    e_src = (op == 4'd1) ? 2'd1 : 2'd0;
    e_alu = is_alu ? 3'(op - 4'd2) : 3'd0;
    n_cmp++;
    if ({ir_opcode, ir_operand, pc, halted, illegal} !== {op, opd, m_pc, 2'b00}) begin
      n_err++;
      $display("FAIL exec_regs: ir=%0h%0h pc=%0h hi=%b%b expected ir=%0h%0h pc=%0h hi=00", ir_opcode, ir_operand, pc, halted, illegal, op, opd, m_pc);
    end
    n_cmp++;
    if ({acc_we, acc_src, alu_op, dmem_re, dmem_we} !== {e_we, e_src, e_alu, op == 4'd7, op == 4'd8}) begin
      n_err++;
      $display("FAIL exec_strobes op=%0h: we/src/alu/re/dwe=%b expected %b", op, {acc_we, acc_src, alu_op, dmem_re, dmem_we}, {e_we, e_src, e_alu, op == 4'd7, op == 4'd8});
    end
    z = (zf == 2) ? 1'($urandom_range(0, 1)) : 1'(zf);
    zero_flag = z;
    if (stop) run = 1'b0;
    if (op == 4'h9 || (op == 4'hA && z) || (op == 4'hB && !z)) m_pc = opd;
    @(posedge clk);
    #1;
    if (op == 4'hF || is_trap) begin
      hlt = 1'b1;
      n_cmp++;
      if ({halted, illegal, acc_we, dmem_re, dmem_we} !== {1'b1, is_trap, 3'b000}) begin
        n_err++;
        $display("FAIL halt_entry: halted/illegal/strobes=%b expected %b", {halted, illegal, acc_we, dmem_re, dmem_we}, {1'b1, is_trap, 3'b000});
      end
    end else if (op == 4'd7) begin
      n_cmp++;
      if ({acc_we, acc_src, dmem_re, dmem_we} !== 5'b1_10_00) begin
        n_err++;
        $display("FAIL mem_cycle: we/src/re/dwe=%b expected 11000", {acc_we, acc_src, dmem_re, dmem_we});
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({pc, ir_opcode, ir_operand, acc_we, dmem_re, dmem_we, alu_op, acc_src, halted, illegal} !== 33'd0) begin
      n_err++;
      $display("FAIL reset_state: pc=%0h ir=%0h%0h strobes=%b alu=%0d src=%0d halted=%b illegal=%b expected all 0", pc, ir_opcode, ir_operand, {acc_we, dmem_re, dmem_we}, alu_op, acc_src, halted, illegal);
    end
  endtask

  task automatic test_ldi();
    bit h;
    clear_rom();
    rom[0] = 12'h105;
    rom[1] = 12'h2F0;
    do_reset();
    start();
    step_instr(1'b0, 0, h);
    step_instr(1'b0, 0, h);
  endtask

  task automatic test_ld();
    bit h;
    clear_rom();
    rom[0] = 12'h70A;
    rom[1] = 12'h133;
    rom[2] = 12'h8C4;
    do_reset();
    start();
    for (int i = 0; i < 3; i++) step_instr(1'b0, 0, h);
  endtask

  task automatic test_jz();
    bit h;
    for (int z = 0; z < 2; z++) begin
      clear_rom();
      rom[0] = 12'hA40;
      rom[1] = 12'h111;
      rom[8'h40] = 12'h177;
      do_reset();
      start();
      step_instr(1'b0, z, h);
      n_cmp++;
      if (pc !== (z == 1 ? 8'h40 : 8'h01)) begin
        n_err++;
        $display("FAIL jz_target zf=%0d: pc=%0h expected %0h", z, pc, (z == 1 ? 8'h40 : 8'h01));
      end
      step_instr(1'b0, 0, h);
    end
  endtask

  task automatic test_wrap();
    bit h;
    clear_rom();
    rom[0] = 12'h9FF;
    rom[8'hFF] = 12'h000;
    do_reset();
    start();
    for (int i = 0; i < 3; i++) step_instr(1'b0, 2, h);
  endtask

  task automatic test_halt();
    bit h;
    clear_rom();
    rom[0] = 12'hF00;
    do_reset();
    start();
    step_instr(1'b0, 0, h);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if ({imem_addr, halted, acc_we, dmem_re, dmem_we} !== {8'h01, 4'b1000}) begin
        n_err++;
        $display("FAIL halt_hold: addr=%0h halted=%b strobes=%b expected addr=01 halted=1 strobes=000", imem_addr, halted, {acc_we, dmem_re, dmem_we});
      end
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({halted, pc} !== 9'd0) begin
      n_err++;
      $display("FAIL halt_reset: halted=%b pc=%0h expected 0/00", halted, pc);
    end
  endtask

  task automatic test_illegal();
    bit h;
    clear_rom();
    rom[0] = 12'hC00;
    rom[1] = 12'h105;
    do_reset();
    start();
    step_instr(1'b0, 0, h);
    n_cmp++;
    if (h !== TRAP) begin
      n_err++;
      $display("FAIL illegal_class: halt=%b expected %b", h, TRAP);
    end
    if (!h) step_instr(1'b0, 0, h);
  endtask

  task automatic test_run_stop();
    bit h;
    clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 12'h100 | 12'(i);
    do_reset();
    start();
    step_instr(1'b1, 0, h);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({acc_we, pc} !== {1'b0, m_pc}) begin
        n_err++;
        $display("FAIL stopped: acc_we=%b pc=%0h expected 0/%0h", acc_we, pc, m_pc);
      end
      @(posedge clk);
      #1;
    end
    start();
    step_instr(1'b0, 0, h);
  endtask

  task automatic test_reset_mid();
    clear_rom();
    rom[0] = 12'h105;
    do_reset();
    start();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({acc_we, acc_src, pc, ir_opcode} !== 15'd0) begin
      n_err++;
      $display("FAIL reset_mid: acc_we=%b src=%0d pc=%0h op=%0h expected all 0", acc_we, acc_src, pc, ir_opcode);
    end
  endtask

  task automatic test_random();
    bit h;
    for (int i = 0; i < 256; i++) rom[i] = {4'($urandom_range(0, TRAP ? 11 : 14)), 8'($urandom)};
    do_reset();
    start();
    for (int n = 0; n < 120; n++) begin
      bit s;
      s = ($urandom_range(0, 7) == 0);
      step_instr(s, 2, h);
      if (s) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        start();
      end
    end
  endtask

  initial begin
    test_reset();
    test_ldi();
    test_ld();
    test_jz();
    test_wrap();
    test_halt();
    test_illegal();
    test_run_stop();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
